// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the memory-side bus responder.
package bus_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_ACCESS,
    RSP_WAIT,
    RSP_DONE
  } rsp_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } bus_op_t;

  localparam logic [31:0] BUS_ERR_RDATA = 32'h0;

endpackage

// File: rtl/bus_responder_if.sv
// Requester-side bus between the CPU memory controller and the responder.
interface bus_responder_if;
  import bus_pkg::*;

  // Handshake: the master holds req_read/req_write (with addr/wdata) as levels and
  // drops them on rsp_valid; the slave samples them only while bus_full is low and
  // signals completion with a one-cycle rsp_valid (rsp_err alongside on a bad address).
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        bus_full;
  logic [31:0] rsp_rdata;
  logic        rsp_valid;
  logic        rsp_err;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  bus_full, rsp_rdata, rsp_valid, rsp_err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output bus_full, rsp_rdata, rsp_valid, rsp_err
  );

endinterface

// File: rtl/bus_responder_latency_counter.sv
// Loadable down-counter that times the SRAM wait window.
module latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_responder.sv
// Memory-side end of the CPU bus: latches one request, strobes a fixed-latency
// word SRAM, and returns a single-cycle completion with optional read data.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  bus_responder_if.slave               bus,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         mem_re,
  output logic                         mem_we,
  input  logic [31:0]                  mem_rdata,
  output rsp_state_t                   dbg_state
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [32:0] SPAN      = 33'(MEM_WORDS) << 2;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  rsp_state_t  state_q, state_d;
  bus_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic [32:0] offset;
  logic        in_range;

  // 33-bit difference so a window that wraps past the top of memory reads as out of range.
  assign offset   = {1'b0, addr_q} - {1'b0, MEM_BASE};
  assign in_range = !offset[32] && (offset < SPAN) && (addr_q[1:0] == 2'b00);

  latency_counter #(.W(CW)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state_q)
      RSP_IDLE: begin
        if (bus.req_read || bus.req_write) begin
          op_d    = bus.req_read ? OP_READ : OP_WRITE;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = RSP_ACCESS;
        end
      end
      RSP_ACCESS: begin
        if (in_range) begin
          mem_re    = (op_q == OP_READ);
          mem_we    = (op_q == OP_WRITE);
          mem_addr  = offset[AW+1:2];
          mem_wdata = wdata_q;
        end
        if (WAIT_CYCLES > 0) begin
          state_d  = RSP_WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d  = RSP_DONE;
        end
      end
      RSP_WAIT: begin
        if (cnt_zero) state_d = RSP_DONE;
        else          cnt_dec = 1'b1;
      end
      RSP_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = !in_range;
        state_d       = RSP_IDLE;
      end
      default: state_d = RSP_IDLE;
    endcase

    // Read data is captured on the edge that enters DONE, when the SRAM output is valid.
    if (state_q != RSP_DONE && state_d == RSP_DONE && op_q == OP_READ)
      rdata_d = in_range ? mem_rdata : BUS_ERR_RDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RSP_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.bus_full  = (state_q != RSP_IDLE);
  assign bus.rsp_rdata = rdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_bus_responder;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_responder_if a_if();
  bus_responder_if b_if();

  logic [9:0]  a_mem_addr, b_mem_addr;
  logic [31:0] a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
  logic        a_mem_re, a_mem_we, b_mem_re, b_mem_we;
  rsp_state_t  a_dbg, b_dbg;

  bus_responder #(.WAIT_CYCLES(2), .MEM_BASE(32'h0), .MEM_WORDS(1024)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_re(a_mem_re),
    .mem_we(a_mem_we), .mem_rdata(a_mem_rdata), .dbg_state(a_dbg)
  );

  bus_responder #(.WAIT_CYCLES(0), .MEM_BASE(32'h0), .MEM_WORDS(1024)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re),
    .mem_we(b_mem_we), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg)
  );

  // SRAM models: data is valid only in the cycle the contract allows, garbage otherwise.
  logic [31:0] sram_a [1024];
  logic [31:0] sram_b [1024];
  logic        a_v1 = 1'b0, a_v2 = 1'b0;
  logic [31:0] a_d1, a_d2;

  always @(posedge clk) begin
    if (a_mem_we) sram_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_we) sram_b[b_mem_addr] <= b_mem_wdata;
    a_v1 <= a_mem_re;
    a_d1 <= sram_a[a_mem_addr];
    a_v2 <= a_v1;
    a_d2 <= a_d1;
  end

  assign a_mem_rdata = a_v2 ? a_d2 : 32'hBAD0_BAD0;
  assign b_mem_rdata = b_mem_re ? sram_b[b_mem_addr] : 32'hBAD0_BAD0;

  // Driver: one request source steered to the selected instance.
  logic        sel = 1'b0;
  logic        drv_read = 1'b0, drv_write = 1'b0;
  logic [31:0] drv_addr = '0, drv_wdata = '0;

  assign a_if.req_read  = drv_read  & ~sel;
  assign a_if.req_write = drv_write & ~sel;
  assign b_if.req_read  = drv_read  &  sel;
  assign b_if.req_write = drv_write &  sel;
  assign a_if.req_addr  = drv_addr;
  assign b_if.req_addr  = drv_addr;
  assign a_if.req_wdata = drv_wdata;
  assign b_if.req_wdata = drv_wdata;

  logic        obs_full, obs_valid, obs_err, obs_re, obs_we;
  logic [31:0] obs_rdata, obs_mwdata;
  logic [9:0]  obs_maddr;

  assign obs_full   = sel ? b_if.bus_full  : a_if.bus_full;
  assign obs_valid  = sel ? b_if.rsp_valid : a_if.rsp_valid;
  assign obs_err    = sel ? b_if.rsp_err   : a_if.rsp_err;
  assign obs_rdata  = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
  assign obs_re     = sel ? b_mem_re       : a_mem_re;
  assign obs_we     = sel ? b_mem_we       : a_mem_we;
  assign obs_maddr  = sel ? b_mem_addr     : a_mem_addr;
  assign obs_mwdata = sel ? b_mem_wdata    : a_mem_wdata;

  // Scoreboard state.
  logic [32:0] exp_q[$];
  logic [31:0] exp_mem [2][1024];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic s, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        is_wr, err;
    logic [9:0]  idx;
    logic [31:0] exp_rd;
    logic [32:0] want;
    int          lat;
    is_wr  = wr & ~rd;
    err    = !((addr < 32'h0000_1000) && (addr[1:0] == 2'b00));
    idx    = addr[11:2];
    exp_rd = rd ? (err ? 32'h0 : exp_mem[s][idx]) : last_rd[s];
    exp_q.push_back({err, exp_rd});
    lat    = s ? 2 : 4;
    sel = s; drv_read = rd; drv_write = wr; drv_addr = addr; drv_wdata = wd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("access_re", obs_re, rd & ~err);
        chk("access_we", obs_we, is_wr & ~err);
        if (!err) chk("access_addr", obs_maddr, idx);
        if (is_wr && !err) chk("access_wdata", obs_mwdata, wd);
        drv_read = 1'b0; drv_write = 1'b0;
        drv_addr = $urandom; drv_wdata = $urandom;
      end else begin
        chk("strobe_off", {obs_re, obs_we}, 2'b00);
      end
      chk("busy", obs_full, 1'b1);
      chk("valid_timing", obs_valid, (k == lat));
      if (k == lat) begin
        want = exp_q.pop_front();
        chk("rsp_err_rdata", {obs_err, obs_rdata}, want);
      end
    end
    @(negedge clk);
    chk("idle_after", {obs_full, obs_valid, obs_err}, 3'b000);
    chk("rdata_held", obs_rdata, exp_rd);
    last_rd[s] = exp_rd;
    if (is_wr && !err) exp_mem[s][idx] = wd;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_idle_a", {a_if.bus_full, a_if.rsp_valid, a_if.rsp_err, a_mem_re, a_mem_we,
                           a_if.rsp_rdata, a_mem_addr, a_mem_wdata, a_dbg}, 64'h0);
    end
  endtask

  initial begin
    logic [31:0] ra, rv;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check(10);
    chk("reset_idle_b", {b_if.bus_full, b_if.rsp_valid, b_mem_re, b_mem_we, b_if.rsp_rdata, b_dbg}, 64'h0);

    do_req(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0);
    do_req(1'b0, 1'b0, 1'b1, 32'h0000_1002, 32'h5555_5555);
    do_req(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222);
    do_req(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h3333_4444);
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    do_req(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D);
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
    do_req(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ra = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      rv = $urandom;
      do_req(1'b0, 1'b0, 1'b1, ra, rv);
      do_req(1'b0, 1'b1, 1'b0, ra, 32'h0);
    end

    // Reset while the A instance sits in WAIT.
    sel = 1'b0; drv_read = 1'b1; drv_addr = 32'h0000_0010;
    @(negedge clk);
    drv_read = 1'b0;
    @(negedge clk);
    chk("in_wait", a_dbg, RSP_WAIT);
    rst = 1'b1;
    #1;
    chk("async_reset", {a_if.bus_full, a_if.rsp_valid, a_mem_re, a_mem_we, a_if.rsp_rdata, a_dbg}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_abort", {a_if.bus_full, a_if.rsp_valid, a_mem_re, a_mem_we, a_if.rsp_rdata}, 64'h0);
    end

    do_req(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE);
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_1001, 32'h0);
    do_req(1'b1, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678);
    do_req(1'b1, 1'b1, 1'b1, 32'h0000_0FFC, 32'h9999_9999);
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
